// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and the decode-facing valid/ready port.
// master = fetch stage, slave = memory/decode side.
interface if_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch PC owner + DEPTH-entry {instr,pc} FIFO; request to out_valid is 2 cycles, no bypass.
// Issue stops once FIFO plus in-flight would exceed DEPTH unless a pop frees a slot; redirect flushes all.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  if_fetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    pop       = (count != '0) & bus.out_ready;
    push      = inflight & ~bus.redirect;
    // A pop in the same cycle frees the slot the new response will land in.
    issue     = ~reset & ~bus.redirect & ((occupancy < (CW+1)'(DEPTH)) | pop);
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = q_instr[head];
  assign bus.out_pc    = q_pc[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~32'h3;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      inflight <= issue;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[tail] <= bus.imem_rdata;
      q_pc[tail]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: DEPTH=2, RESET_PC=0, memory returns addr ^ 32'hA5A5_0000.
module tb_if_fetch_queue;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  if_fetch_queue_if bus();

  if_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clock) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ 32'hA5A5_0000;
  end

  logic [31:0] log_q [$];
  logic [31:0] exp_q [$];

  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) log_q.push_back(bus.out_pc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rdir, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    reset           = rst;
    bus.out_ready   = rdy;
    bus.redirect    = rdir;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc);
    check({tag, ".req"}, {31'b0, bus.imem_req}, {31'b0, req});
    if (req) check({tag, ".addr"}, bus.imem_addr, addr);
    check({tag, ".vld"}, {31'b0, bus.out_valid}, {31'b0, vld});
    if (vld) begin
      check({tag, ".pc"}, bus.out_pc, pc);
      check({tag, ".instr"}, bus.out_instr, pc ^ 32'hA5A5_0000);
    end
  endtask

  task automatic check_log(input string tag);
    @(negedge clock);
    #1;
    check({tag, ".len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.pc%0d", tag, i), (i < log_q.size()) ? log_q[i] : 32'hxxxx_xxxx, exp_q[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 required");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset, then free-run at one word per cycle.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    expect_cyc("rst", 0, 0, 0, 0);
    log_q.delete();
    step(0, 1, 0, 0); expect_cyc("run0", 1, 32'h0,  0, 0);
    step(0, 1, 0, 0); expect_cyc("run1", 1, 32'h4,  0, 0);
    step(0, 1, 0, 0); expect_cyc("run2", 1, 32'h8,  1, 32'h0);
    step(0, 1, 0, 0); expect_cyc("run3", 1, 32'hC,  1, 32'h4);
    step(0, 1, 0, 0); expect_cyc("run4", 1, 32'h10, 1, 32'h8);

    // Stall: exactly DEPTH requests, head held, then drain in order.
    step(1, 0, 0, 0);
    log_q.delete();
    step(0, 0, 0, 0); expect_cyc("st0", 1, 32'h0,  0, 0);
    step(0, 0, 0, 0); expect_cyc("st1", 1, 32'h4,  0, 0);
    step(0, 0, 0, 0); expect_cyc("st2", 0, 0,      1, 32'h0);
    step(0, 0, 0, 0); expect_cyc("st3", 0, 0,      1, 32'h0);
    step(0, 0, 0, 0); expect_cyc("st4", 0, 0,      1, 32'h0);
    step(0, 1, 0, 0); expect_cyc("st5", 1, 32'h8,  1, 32'h0);
    step(0, 1, 0, 0); expect_cyc("st6", 1, 32'hC,  1, 32'h4);
    step(0, 1, 0, 0); expect_cyc("st7", 1, 32'h10, 1, 32'h8);
    exp_q = '{32'h0, 32'h4, 32'h8};
    check_log("stall_log");

    // Redirect while pc 8 is in flight; pc 4 pops in the redirect cycle.
    step(1, 1, 0, 0);
    log_q.delete();
    step(0, 1, 0, 0);            expect_cyc("rd0", 1, 32'h0,   0, 0);
    step(0, 1, 0, 0);            expect_cyc("rd1", 1, 32'h4,   0, 0);
    step(0, 1, 0, 0);            expect_cyc("rd2", 1, 32'h8,   1, 32'h0);
    step(0, 1, 1, 32'h0000_0102); expect_cyc("rd3", 0, 0,       1, 32'h4);
    step(0, 1, 0, 0);            expect_cyc("rd4", 1, 32'h100, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("rd5", 1, 32'h104, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("rd6", 1, 32'h108, 1, 32'h100);
    step(0, 1, 0, 0);            expect_cyc("rd7", 1, 32'h10C, 1, 32'h104);
    exp_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    check_log("redir_log");

    // Wrap-around through 32'hFFFF_FFFC; low redirect bits are ignored.
    step(1, 1, 0, 0);
    log_q.delete();
    step(0, 1, 0, 0);            expect_cyc("wr0", 1, 32'h0, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("wr1", 1, 32'h4, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("wr2", 1, 32'h8, 1, 32'h0);
    step(0, 1, 1, 32'hFFFF_FFFB); expect_cyc("wr3", 0, 0,     1, 32'h4);
    step(0, 1, 0, 0);            expect_cyc("wr4", 1, 32'hFFFF_FFF8, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("wr5", 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 1, 0, 0);            expect_cyc("wr6", 1, 32'h0, 1, 32'hFFFF_FFF8);
    step(0, 1, 0, 0);            expect_cyc("wr7", 1, 32'h4, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);            expect_cyc("wr8", 1, 32'h8, 1, 32'h0);
    step(0, 1, 0, 0);            expect_cyc("wr9", 1, 32'hC, 1, 32'h4);
    exp_q = '{32'h0, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    check_log("wrap_log");

    // Back-to-back redirects (last wins), then reset mid-stream.
    step(1, 1, 0, 0);
    log_q.delete();
    step(0, 1, 1, 32'h300); expect_cyc("mr0", 0, 0, 0, 0);
    step(0, 1, 1, 32'h200); expect_cyc("mr1", 0, 0, 0, 0);
    step(0, 1, 0, 0);       expect_cyc("mr2", 1, 32'h200, 0, 0);
    step(0, 1, 0, 0);       expect_cyc("mr3", 1, 32'h204, 0, 0);
    step(0, 1, 0, 0);       expect_cyc("mr4", 1, 32'h208, 1, 32'h200);
    step(1, 1, 0, 0);
    check("mr5.req", {31'b0, bus.imem_req}, 32'h0);
    step(0, 1, 0, 0);       expect_cyc("mr6", 1, 32'h0, 0, 0);
    step(0, 1, 0, 0);       expect_cyc("mr7", 1, 32'h4, 0, 0);
    step(0, 1, 0, 0);       expect_cyc("mr8", 1, 32'h8, 1, 32'h0);
    step(0, 1, 0, 0);       expect_cyc("mr9", 1, 32'hC, 1, 32'h4);
    exp_q = '{32'h200, 32'h0, 32'h4};
    check_log("mrst_log");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
